// File: rtl/axis_diff_scheduler.sv
// Feeds a decimated AXI-Stream into an external differentiator, drops warm-up results and
// buffers the rest in a 2-deep output FIFO. Define AXIS_DIFF_SCHED_COUNT_EN to add sample_count.
module axis_diff_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DECIM_WIDTH      = 16,
  parameter int WARMUP           = 6
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [DECIM_WIDTH-1:0]      decimation,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  output logic                        D_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] D_AXIS_tdata,
  input  logic                        R_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] R_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  input  logic                        M_AXIS_tready,
  output logic                        busy
`ifdef AXIS_DIFF_SCHED_COUNT_EN
  ,
  output logic [31:0]                 sample_count
`endif
);
  localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [DECIM_WIDTH-1:0]      dec_q, dec_d, dec_cnt_q, dec_cnt_d;
  logic [1:0]                  inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
  logic [WW-1:0]               warm_q, warm_d;
  logic [AXIS_TDATA_WIDTH-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [AXIS_TDATA_WIDTH-1:0] d_tdata_q, d_tdata_d;
  logic                        d_tvalid_q, d_tvalid_d;
  logic                        s_tready_q, s_tready_d;
  logic                        busy_q, busy_d;
  logic                        acc, push, pop, r_take;
  logic [2:0]                  occ;
`ifdef AXIS_DIFF_SCHED_COUNT_EN
  logic [31:0]                 cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    dec_d      = dec_q;
    dec_cnt_d  = dec_cnt_q;
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    warm_d     = warm_q;
    mem0_d     = mem0_q;
    mem1_d     = mem1_q;
    d_tdata_d  = d_tdata_q;
    d_tvalid_d = 1'b0;
    acc        = S_AXIS_tvalid && s_tready_q;
    push       = 1'b0;
    pop        = (fifo_cnt_q != 2'd0) && M_AXIS_tready;
    r_take     = 1'b0;
`ifdef AXIS_DIFF_SCHED_COUNT_EN
    cnt_d      = cnt_q + {31'd0, pop};
`endif

    // A result with nothing outstanding is stray (e.g. left over from before a reset).
    if (state_q != IDLE) begin
      r_take = R_AXIS_tvalid && ((inflight_q != 2'd0) || d_tvalid_q);
      case ({d_tvalid_q, r_take})
        2'b10:   inflight_d = inflight_q + 2'd1;
        2'b01:   inflight_d = inflight_q - 2'd1;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = PRIME;
          dec_d      = (decimation == '0) ? DECIM_WIDTH'(1) : decimation;
          dec_cnt_d  = '0;
          inflight_d = '0;
          warm_d     = '0;
`ifdef AXIS_DIFF_SCHED_COUNT_EN
          cnt_d      = '0;
`endif
        end
      end
      PRIME, RUN: begin
        if (acc) begin
          d_tvalid_d = (dec_cnt_q == '0);
          if (dec_cnt_q == '0) d_tdata_d = S_AXIS_tdata;
          dec_cnt_d = (dec_cnt_q == dec_q - 1'b1) ? '0 : dec_cnt_q + 1'b1;
        end
        if (state_q == RUN) begin
          push = R_AXIS_tvalid;
        end else if (WARMUP == 0) begin
          state_d = RUN;
        end else if (R_AXIS_tvalid) begin
          warm_d = warm_q + 1'b1;
          if (warm_q == WW'(WARMUP - 1)) state_d = RUN;
        end
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        push = R_AXIS_tvalid;
        if (inflight_q == 2'd0 && fifo_cnt_q == 2'd0 && !d_tvalid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Head lives in mem0; a push while popping a single entry goes straight to the head.
    case ({push, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) mem0_d = R_AXIS_tdata;
        else                    mem1_d = R_AXIS_tdata;
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        mem0_d     = mem1_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) mem0_d = R_AXIS_tdata;
        else begin
          mem0_d = mem1_q;
          mem1_d = R_AXIS_tdata;
        end
      end
      default: ;
    endcase

    // Ready is registered, so count the D pulse about to be issued as already in flight.
    occ = {1'b0, fifo_cnt_d} + {1'b0, inflight_d} + {2'b00, d_tvalid_d};
    case (state_d)
      IDLE:    s_tready_d = 1'b1;
      DRAIN:   s_tready_d = 1'b0;
      default: s_tready_d = (occ < 3'd2);
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      dec_q      <= DECIM_WIDTH'(1);
      dec_cnt_q  <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      warm_q     <= '0;
      mem0_q     <= '0;
      mem1_q     <= '0;
      d_tdata_q  <= '0;
      d_tvalid_q <= 1'b0;
      s_tready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef AXIS_DIFF_SCHED_COUNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dec_q      <= dec_d;
      dec_cnt_q  <= dec_cnt_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      warm_q     <= warm_d;
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
      d_tdata_q  <= d_tdata_d;
      d_tvalid_q <= d_tvalid_d;
      s_tready_q <= s_tready_d;
      busy_q     <= busy_d;
`ifdef AXIS_DIFF_SCHED_COUNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign S_AXIS_tready = s_tready_q;
  assign D_AXIS_tvalid = d_tvalid_q;
  assign D_AXIS_tdata  = d_tdata_q;
  assign M_AXIS_tvalid = (fifo_cnt_q != 2'd0);
  assign M_AXIS_tdata  = mem0_q;
  assign busy          = busy_q;
`ifdef AXIS_DIFF_SCHED_COUNT_EN
  assign sample_count  = cnt_q;
`endif

endmodule
